// File: rtl/dct32_in_butterfly.sv
// First DCT32 stage: gathers 32 serial samples into a ping-pong buffer and presents the
// even/odd butterfly terms a[k], b[k] in parallel. Define DCT32_ERR_CNT_EN to add err_cnt.
module dct32_in_butterfly #(
  parameter int IN_WIDTH = 16,
  parameter int WIDTH    = 20
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_valid,
  input  logic                  in_sop,
  output logic                  in_ready,
  output logic [16*WIDTH-1:0]   a_bus,
  output logic [16*WIDTH-1:0]   b_bus,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sop_err
`ifdef DCT32_ERR_CNT_EN
  ,
  output logic [7:0]            err_cnt
`endif
);

  logic [IN_WIDTH-1:0] mem [2][32];
  logic [4:0]          cnt;
  logic                wr_bank;
  logic                rd_bank;
  logic [1:0]          full;
  logic [1:0]          full_next;
  logic                accept;
  logic                done;
  logic                load;
  logic                sop_abort;
  logic [16*WIDTH-1:0] a_next;
  logic [16*WIDTH-1:0] b_next;

  // in_ready comes from registered state only, so out_ready never reaches it combinationally.
  assign in_ready  = !full[wr_bank];
  assign accept    = in_valid && in_ready;
  assign sop_abort = accept && in_sop && (cnt != 5'd0);
  assign done      = accept && !in_sop && (cnt == 5'd31);
  assign load      = full[rd_bank] && (!out_valid || out_ready);

  // The writer only ever sets the bank it is filling and the reader only clears a full
  // bank, so the two updates never target the same flag.
  always_comb begin
    // NOTE: default assignment first so no path leaves full_next unassigned (no latch).
    full_next = full;
    if (load) full_next[rd_bank] = 1'b0;
    if (done) full_next[wr_bank] = 1'b1;
  end

  // NOTE: the sample store has no reset; the full flags decide whether its contents matter.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_bank][in_sop ? 5'd0 : cnt] <= in_data;
  end

  for (genvar k = 0; k < 16; k++) begin : g_bfly
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    assign lo = {{(WIDTH-IN_WIDTH){mem[rd_bank][k][IN_WIDTH-1]}}, mem[rd_bank][k]};
    assign hi = {{(WIDTH-IN_WIDTH){mem[rd_bank][31-k][IN_WIDTH-1]}}, mem[rd_bank][31-k]};
    assign a_next[k*WIDTH +: WIDTH] = lo + hi;
    assign b_next[k*WIDTH +: WIDTH] = lo - hi;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      // NOTE: non-blocking assignments for all sequential state avoid ordering races.
      cnt       <= 5'd0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full      <= 2'b00;
      out_valid <= 1'b0;
      a_bus     <= '0;
      b_bus     <= '0;
      sop_err   <= 1'b0;
    end else begin
      full <= full_next;
      if (accept) begin
        // An x0 marker restarts the block; otherwise the counter wraps 31 -> 0.
        if (in_sop) cnt <= 5'd1;
        else        cnt <= cnt + 5'd1;
      end
      if (done)      wr_bank <= !wr_bank;
      if (sop_abort) sop_err <= 1'b1;
      if (load) begin
        a_bus     <= a_next;
        b_bus     <= b_next;
        out_valid <= 1'b1;
        rd_bank   <= !rd_bank;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef DCT32_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_b)                            err_cnt <= 8'd0;
    else if (sop_abort && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_dct32_in_butterfly.sv
// Directed self-checking bench for dct32_in_butterfly; expected buses come from
// closed-form butterfly results of simple sample patterns.
module tb_dct32_in_butterfly;
  localparam int IW = 16;
  localparam int W  = 20;

  logic            clk = 1'b0;
  logic            rst_b;
  logic [IW-1:0]   in_data;
  logic            in_valid;
  logic            in_sop;
  logic            in_ready;
  logic [16*W-1:0] a_bus;
  logic [16*W-1:0] b_bus;
  logic            out_valid;
  logic            out_ready;
  logic            sop_err;
`ifdef DCT32_ERR_CNT_EN
  logic [7:0]      err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  dct32_in_butterfly #(.IN_WIDTH(IW), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .in_ready  (in_ready),
    .a_bus     (a_bus),
    .b_bus     (b_bus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sop_err   (sop_err)
`ifdef DCT32_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // For x[n] = c + s*n: a[k] = 2c + 31s, b[k] = (2k-31)*s.
  function automatic logic [16*W-1:0] pack_a(input int c, input int s);
    logic [16*W-1:0] r;
    for (int k = 0; k < 16; k++) r[k*W +: W] = W'(2*c + 31*s);
    return r;
  endfunction

  function automatic logic [16*W-1:0] pack_b(input int s);
    logic [16*W-1:0] r;
    for (int k = 0; k < 16; k++) r[k*W +: W] = W'((2*k - 31) * s);
    return r;
  endfunction

  // For x[n] = n*n: a[k] = k^2 + (31-k)^2, b[k] = 31*(2k-31).
  function automatic logic [16*W-1:0] sq_a();
    logic [16*W-1:0] r;
    for (int k = 0; k < 16; k++) r[k*W +: W] = W'(k*k + (31-k)*(31-k));
    return r;
  endfunction

  function automatic logic [16*W-1:0] sq_b();
    logic [16*W-1:0] r;
    for (int k = 0; k < 16; k++) r[k*W +: W] = W'(31 * (2*k - 31));
    return r;
  endfunction

  task automatic send(input int d, input logic sop);
    int waited = 0;
    in_data  = IW'(d);
    in_sop   = sop;
    in_valid = 1'b1;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  task automatic send_lin(input int c, input int s, input logic sop_first);
    for (int n = 0; n < 32; n++) send(c + s*n, sop_first && (n == 0));
  endtask

  task automatic test_reset();
    rst_b = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
    checks++; if (a_bus !== '0) begin errors++; $display("FAIL reset_a_bus got %h expected 0", a_bus); end
    checks++; if (b_bus !== '0) begin errors++; $display("FAIL reset_b_bus got %h expected 0", b_bus); end
    checks++; if (sop_err !== 1'b0) begin errors++; $display("FAIL reset_sop_err got %b expected 0", sop_err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
`ifdef DCT32_ERR_CNT_EN
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got %0d expected 0", err_cnt); end
`endif
    rst_b = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ramp_latency();
    out_ready = 1'b1;
    send_lin(0, 1, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ramp_t1_valid got %b expected 0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ramp_t2_valid got %b expected 1", out_valid); end
    checks++; if (a_bus !== pack_a(0, 1)) begin errors++; $display("FAIL ramp_a got %h expected %h", a_bus, pack_a(0, 1)); end
    checks++; if (b_bus !== pack_b(1)) begin errors++; $display("FAIL ramp_b got %h expected %h", b_bus, pack_b(1)); end
    checks++; if (sop_err !== 1'b0) begin errors++; $display("FAIL ramp_sop_err got %b expected 0", sop_err); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ramp_drain got %b expected 0", out_valid); end
  endtask

  task automatic test_sign_extend();
    logic [16*W-1:0] exp_bus;
    exp_bus = '0;
    exp_bus[W-1:0] = 20'hF8000;
    out_ready = 1'b1;
    send(-32768, 1'b0);
    for (int n = 1; n < 32; n++) send(0, 1'b0);
    @(posedge clk); #1;
    checks++; if (a_bus !== exp_bus) begin errors++; $display("FAIL signext_a got %h expected %h", a_bus, exp_bus); end
    checks++; if (b_bus !== exp_bus) begin errors++; $display("FAIL signext_b got %h expected %h", b_bus, exp_bus); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int got = 0, stalls = 0, cyc0 = 0, cyc1 = 0;
    logic [16*W-1:0] a0, b0, a1, b1;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    out_ready = 1'b1;
    fork
      begin
        send_lin(1, 3, 1'b1);
        send_lin(0, -4, 1'b0);
      end
      begin
        for (int c = 0; c < 150 && got < 2; c++) begin
          @(posedge clk); #1;
          if (!in_ready) stalls++;
          if (out_valid) begin
            if (got == 0) begin a0 = a_bus; b0 = b_bus; cyc0 = c; end
            else          begin a1 = a_bus; b1 = b_bus; cyc1 = c; end
            got++;
          end
        end
      end
    join
    checks++; if (got !== 2) begin errors++; $display("FAIL b2b_blocks got %0d expected 2", got); end
    checks++; if (stalls !== 0) begin errors++; $display("FAIL b2b_stalls got %0d expected 0", stalls); end
    checks++; if (cyc1 - cyc0 !== 32) begin errors++; $display("FAIL b2b_spacing got %0d expected 32", cyc1 - cyc0); end
    checks++; if (a0 !== pack_a(1, 3)) begin errors++; $display("FAIL b2b_a0 got %h expected %h", a0, pack_a(1, 3)); end
    checks++; if (b0 !== pack_b(3)) begin errors++; $display("FAIL b2b_b0 got %h expected %h", b0, pack_b(3)); end
    checks++; if (a1 !== pack_a(0, -4)) begin errors++; $display("FAIL b2b_a1 got %h expected %h", a1, pack_a(0, -4)); end
    checks++; if (b1 !== pack_b(-4)) begin errors++; $display("FAIL b2b_b1 got %h expected %h", b1, pack_b(-4)); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_start_valid got %b expected 0", out_valid); end
    send_lin(1000, -3, 1'b1);
    send_lin(-500, 7, 1'b0);
    for (int n = 0; n < 32; n++) send(n*n, 1'b0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low got %b expected 0", in_ready); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_hold got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got %b expected 1", out_valid); end
    checks++; if (a_bus !== pack_a(1000, -3)) begin errors++; $display("FAIL bp_blk1_a got %h expected %h", a_bus, pack_a(1000, -3)); end
    checks++; if (b_bus !== pack_b(-3)) begin errors++; $display("FAIL bp_blk1_b got %h expected %h", b_bus, pack_b(-3)); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_back got %b expected 1", in_ready); end
    checks++; if (a_bus !== pack_a(-500, 7)) begin errors++; $display("FAIL bp_blk2_a got %h expected %h", a_bus, pack_a(-500, 7)); end
    checks++; if (b_bus !== pack_b(7)) begin errors++; $display("FAIL bp_blk2_b got %h expected %h", b_bus, pack_b(7)); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (a_bus !== sq_a()) begin errors++; $display("FAIL bp_blk3_a got %h expected %h", a_bus, sq_a()); end
    checks++; if (b_bus !== sq_b()) begin errors++; $display("FAIL bp_blk3_b got %h expected %h", b_bus, sq_b()); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b expected 0", out_valid); end
  endtask

  task automatic test_sop_abort();
    out_ready = 1'b1;
    for (int n = 0; n < 10; n++) send(9999, 1'b0);
    checks++; if (sop_err !== 1'b0) begin errors++; $display("FAIL sop_pre_err got %b expected 0", sop_err); end
    send(-80, 1'b1);
    checks++; if (sop_err !== 1'b1) begin errors++; $display("FAIL sop_err_set got %b expected 1", sop_err); end
    for (int n = 1; n < 32; n++) send(-80 + 5*n, 1'b0);
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sop_valid got %b expected 1", out_valid); end
    checks++; if (a_bus !== pack_a(-80, 5)) begin errors++; $display("FAIL sop_a got %h expected %h", a_bus, pack_a(-80, 5)); end
    checks++; if (b_bus !== pack_b(5)) begin errors++; $display("FAIL sop_b got %h expected %h", b_bus, pack_b(5)); end
    checks++; if (sop_err !== 1'b1) begin errors++; $display("FAIL sop_err_sticky got %b expected 1", sop_err); end
`ifdef DCT32_ERR_CNT_EN
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL sop_err_cnt got %0d expected 1", err_cnt); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_block();
    out_ready = 1'b0;
    send_lin(200, -1, 1'b0);
    @(posedge clk); #1;
    checks++; if (a_bus !== pack_a(200, -1)) begin errors++; $display("FAIL rmid_loaded_a got %h expected %h", a_bus, pack_a(200, -1)); end
    for (int n = 0; n < 20; n++) send(1234, 1'b0);
    rst_b = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b expected 0", out_valid); end
    checks++; if (a_bus !== '0) begin errors++; $display("FAIL rmid_a got %h expected 0", a_bus); end
    checks++; if (b_bus !== '0) begin errors++; $display("FAIL rmid_b got %h expected 0", b_bus); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b expected 1", in_ready); end
    checks++; if (sop_err !== 1'b0) begin errors++; $display("FAIL rmid_sop_err got %b expected 0", sop_err); end
    rst_b = 1'b1;
    out_ready = 1'b1;
    send_lin(7, -2, 1'b0);
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rpost_valid got %b expected 1", out_valid); end
    checks++; if (a_bus !== pack_a(7, -2)) begin errors++; $display("FAIL rpost_a got %h expected %h", a_bus, pack_a(7, -2)); end
    checks++; if (b_bus !== pack_b(-2)) begin errors++; $display("FAIL rpost_b got %h expected %h", b_bus, pack_b(-2)); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_ramp_latency();
    test_sign_extend();
    test_back_to_back();
    test_backpressure();
    test_sop_abort();
    test_reset_mid_block();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
